ram_arbiter_2p: RTL and testbench

//  Shares one single_port_ram instance between two requesters (A, B) and a clear source.

---
 rtl/ram_arbiter_2p_pkg.sv | 19 +
 rtl/ram_arbiter_2p_rr_arb2.sv | 34 +++
 rtl/ram_arbiter_2p.sv | 164 ++++++++++++++++
 tb/tb_ram_arbiter_2p.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arbiter_2p_pkg.sv
// Shared types for the two-port RAM arbiter: FSM states, op codes, client ids.
package ram_arbiter_2p_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RDWAIT = 2'd2,
        ST_CLEAR  = 2'd3
    } state_t;

    localparam logic OP_RD = 1'b0;
    localparam logic OP_WR = 1'b1;

    typedef enum logic {
        CLIENT_A = 1'b0,
        CLIENT_B = 1'b1
    } client_t;

endpackage

// File: rtl/ram_arbiter_2p_rr_arb2.sv
// Two-way round-robin picker: a single requester wins outright, a tie goes to
// the client that was not granted last. The pointer moves only on advance.
module rr_arb2
    import ram_arbiter_2p_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    client_t last;

    // Pick the winner from the request pair and the last-granted pointer.
    always_comb begin
        // NOTE: assign every always_comb output first so no path leaves it unassigned (no latch).
        gnt = req;
        if (req == 2'b11) begin
            gnt = (last == CLIENT_B) ? 2'b01 : 2'b10;
        end
    end

    // Pointer flop; resets to "B last" so A wins the first tie.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: state flops use non-blocking assignments so all flops update from pre-edge values.
        if (!rst) begin
            last <= CLIENT_B;
        end else if (advance) begin
            last <= gnt[1] ? CLIENT_B : CLIENT_A;
        end
    end

endmodule

// File: rtl/ram_arbiter_2p.sv
// Shares one single-port RAM between clients A and B plus a clear source.
// One access in flight; every output, including the RAM strobes, is a flop.
module ram_arbiter_2p
    import ram_arbiter_2p_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_req,
    input  logic              a_wr,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_gnt,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_wr,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_gnt,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] b_rdata,
    input  logic              clr_req,
    output logic              clr_done,
    output logic              ram_cs,
    output logic              ram_wr,
    output logic              ram_rd,
    output logic              ram_rst,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              busy
);

    state_t  state_q, state_d;
    logic    op_q, op_d;
    client_t owner_q, owner_d;

    logic [1:0]        arb_gnt;
    logic              advance;
    logic              a_gnt_d, b_gnt_d, a_rvalid_d, b_rvalid_d;
    logic              clr_done_d, cs_d, wr_d, rd_d, ram_rst_d;
    logic [ADDR_W-1:0] addr_d;
    logic [DATA_W-1:0] wdata_d;

    rr_arb2 u_rr_arb2 (
        .clk     (clk),
        .rst     (rst),
        .req     ({b_req, a_req}),
        .advance (advance),
        .gnt     (arb_gnt)
    );

    // Next-state and next-output decode; the clear source outranks both clients.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        owner_d    = owner_q;
        advance    = 1'b0;
        a_gnt_d    = 1'b0;
        b_gnt_d    = 1'b0;
        a_rvalid_d = 1'b0;
        b_rvalid_d = 1'b0;
        clr_done_d = 1'b0;
        cs_d       = 1'b0;
        wr_d       = 1'b0;
        rd_d       = 1'b0;
        ram_rst_d  = 1'b0;
        addr_d     = ram_addr;
        wdata_d    = ram_wdata;
        unique case (state_q)
            ST_IDLE: begin
                if (clr_req) begin
                    ram_rst_d = 1'b1;
                    state_d   = ST_CLEAR;
                end else if (arb_gnt != 2'b00) begin
                    advance = 1'b1;
                    owner_d = arb_gnt[1] ? CLIENT_B : CLIENT_A;
                    op_d    = arb_gnt[1] ? b_wr    : a_wr;
                    addr_d  = arb_gnt[1] ? b_addr  : a_addr;
                    wdata_d = arb_gnt[1] ? b_wdata : a_wdata;
                    a_gnt_d = arb_gnt[0];
                    b_gnt_d = arb_gnt[1];
                    cs_d    = 1'b1;
                    wr_d    = (op_d == OP_WR);
                    rd_d    = (op_d == OP_RD);
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                state_d = (op_q == OP_WR) ? ST_IDLE : ST_RDWAIT;
            end
            ST_RDWAIT: begin
                a_rvalid_d = (owner_q == CLIENT_A);
                b_rvalid_d = (owner_q == CLIENT_B);
                state_d    = ST_IDLE;
            end
            ST_CLEAR: begin
                clr_done_d = 1'b1;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM state plus the latched op and owner of the access in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            op_q    <= OP_RD;
            owner_q <= CLIENT_A;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            owner_q <= owner_d;
        end
    end

    // Registered handshakes and RAM pins; reset drops every strobe at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_gnt     <= 1'b0;
            b_gnt     <= 1'b0;
            a_rvalid  <= 1'b0;
            b_rvalid  <= 1'b0;
            clr_done  <= 1'b0;
            ram_cs    <= 1'b0;
            ram_wr    <= 1'b0;
            ram_rd    <= 1'b0;
            ram_rst   <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            busy      <= 1'b0;
        end else begin
            a_gnt     <= a_gnt_d;
            b_gnt     <= b_gnt_d;
            a_rvalid  <= a_rvalid_d;
            b_rvalid  <= b_rvalid_d;
            clr_done  <= clr_done_d;
            ram_cs    <= cs_d;
            ram_wr    <= wr_d;
            ram_rd    <= rd_d;
            ram_rst   <= ram_rst_d;
            ram_addr  <= addr_d;
            ram_wdata <= wdata_d;
            busy      <= (state_d != ST_IDLE);
        end
    end

    // Per-client read data, held until that client's next read completes.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: these are plain data registers, so they take reset to make every output read 0.
        if (!rst) begin
            a_rdata <= '0;
            b_rdata <= '0;
        end else begin
            if (a_rvalid_d) a_rdata <= ram_rdata;
            if (b_rvalid_d) b_rdata <= ram_rdata;
        end
    end

endmodule

// File: tb/tb_ram_arbiter_2p.sv
// Directed bench for ram_arbiter_2p with a behavioural single-port RAM model.
module tb_ram_arbiter_2p;

    logic       clk;
    logic       rst;
    logic       a_req, a_wr, b_req, b_wr, clr_req;
    logic [9:0] a_addr, b_addr;
    logic [7:0] a_wdata, b_wdata;
    logic       a_gnt, a_rvalid, b_gnt, b_rvalid, clr_done;
    logic [7:0] a_rdata, b_rdata;
    logic       ram_cs, ram_wr, ram_rd, ram_rst, busy;
    logic [9:0] ram_addr;
    logic [7:0] ram_wdata, ram_rdata;

    int n_asserts = 0;
    int n_fail    = 0;
    logic prev_a_gnt = 1'b0;
    logic prev_b_gnt = 1'b0;
    logic [7:0] exp_a_rdata = 8'h00;
    logic [7:0] exp_b_rdata = 8'h00;
    int grants = 0;

    typedef struct {
        logic       is_b;
        logic       wr;
        logic [9:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp_rdata;
    } vec_t;
    vec_t vecs [7];

    ram_arbiter_2p #(.DATA_W(8), .ADDR_W(10)) dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_wr(a_wr), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_req(b_req), .b_wr(b_wr), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .clr_req(clr_req), .clr_done(clr_done),
        .ram_cs(ram_cs), .ram_wr(ram_wr), .ram_rd(ram_rd), .ram_rst(ram_rst),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single-port RAM model: synchronous clear, write, registered read.
    logic [7:0] mem [0:1023];
    always @(posedge clk) begin
        if (ram_rst) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 8'h00;
        end else begin
            if (ram_cs && ram_wr) mem[ram_addr] <= ram_wdata;
            if (ram_cs && ram_rd) ram_rdata <= mem[ram_addr];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_asserts++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance to the next falling edge and run the every-cycle protocol checks.
    task automatic tick();
        @(negedge clk);
        check("no_wr_and_rd", {31'd0, ram_wr & ram_rd}, 0);
        check("no_rst_and_cs", {31'd0, ram_rst & ram_cs}, 0);
        check("a_gnt_one_cycle", {31'd0, a_gnt & prev_a_gnt}, 0);
        check("b_gnt_one_cycle", {31'd0, b_gnt & prev_b_gnt}, 0);
        prev_a_gnt = a_gnt;
        prev_b_gnt = b_gnt;
    endtask

    task automatic drive(input logic is_b, input logic req, input logic wr,
                         input logic [9:0] addr, input logic [7:0] wdata);
        if (is_b) begin
            b_req = req; b_wr = wr; b_addr = addr; b_wdata = wdata;
        end else begin
            a_req = req; a_wr = wr; a_addr = addr; a_wdata = wdata;
        end
    endtask

    task automatic wait_gnt(input logic is_b, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (is_b ? b_gnt : a_gnt) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // One complete access by one client, checking strobes, latency and data.
    task automatic do_access(input string tag, input logic is_b, input logic wr,
                             input logic [9:0] addr, input logic [7:0] wdata,
                             input logic [7:0] exp_rd);
        logic ok;
        drive(is_b, 1'b1, wr, addr, wdata);
        wait_gnt(is_b, ok);
        check({tag, "_gnt_seen"}, {31'd0, ok}, 1);
        check({tag, "_cs"}, {31'd0, ram_cs}, 1);
        check({tag, "_wr"}, {31'd0, ram_wr}, {31'd0, wr});
        check({tag, "_rd"}, {31'd0, ram_rd}, {31'd0, ~wr});
        check({tag, "_addr"}, {22'd0, ram_addr}, {22'd0, addr});
        if (wr) check({tag, "_wdata"}, {24'd0, ram_wdata}, {24'd0, wdata});
        check({tag, "_other_gnt"}, {31'd0, is_b ? a_gnt : b_gnt}, 0);
        check({tag, "_busy"}, {31'd0, busy}, 1);
        // Drop the request and scramble the fields: the latched copy must be used.
        drive(is_b, 1'b0, ~wr, ~addr, ~wdata);
        tick();
        check({tag, "_cs_drop"}, {31'd0, ram_cs}, 0);
        if (wr) begin
            check({tag, "_idle_after_wr"}, {31'd0, busy}, 0);
        end else begin
            check({tag, "_no_early_rvalid"}, {31'd0, is_b ? b_rvalid : a_rvalid}, 0);
            tick();
            check({tag, "_rvalid"}, {31'd0, is_b ? b_rvalid : a_rvalid}, 1);
            check({tag, "_other_rvalid"}, {31'd0, is_b ? a_rvalid : b_rvalid}, 0);
            if (is_b) exp_b_rdata = exp_rd;
            else      exp_a_rdata = exp_rd;
        end
        check({tag, "_a_rdata"}, {24'd0, a_rdata}, {24'd0, exp_a_rdata});
        check({tag, "_b_rdata"}, {24'd0, b_rdata}, {24'd0, exp_b_rdata});
    endtask

    // One contention cycle: track grant order and confirm neither rdata disturbs the other.
    task automatic cont_step();
        tick();
        if (a_rvalid) exp_a_rdata = 8'hA5;
        if (b_rvalid) exp_b_rdata = 8'h5A;
        check("cont_a_rdata", {24'd0, a_rdata}, {24'd0, exp_a_rdata});
        check("cont_b_rdata", {24'd0, b_rdata}, {24'd0, exp_b_rdata});
        if ((a_gnt || b_gnt) && grants < 6) begin
            check("cont_order", {31'd0, b_gnt}, grants % 2);
            check("cont_gnt_excl", {31'd0, a_gnt & b_gnt}, 0);
            grants++;
            if (grants == 6) begin
                a_req = 1'b0;
                b_req = 1'b0;
            end
        end
    endtask

    initial begin
        logic ok;
        vecs[0] = '{is_b: 1'b0, wr: 1'b1, addr: 10'h3FF, wdata: 8'hA5, exp_rdata: 8'h00};
        vecs[1] = '{is_b: 1'b0, wr: 1'b0, addr: 10'h3FF, wdata: 8'h00, exp_rdata: 8'hA5};
        vecs[2] = '{is_b: 1'b1, wr: 1'b1, addr: 10'h000, wdata: 8'h5A, exp_rdata: 8'h00};
        vecs[3] = '{is_b: 1'b0, wr: 1'b1, addr: 10'h155, wdata: 8'h3C, exp_rdata: 8'h00};
        vecs[4] = '{is_b: 1'b1, wr: 1'b0, addr: 10'h155, wdata: 8'h00, exp_rdata: 8'h3C};
        vecs[5] = '{is_b: 1'b0, wr: 1'b0, addr: 10'h000, wdata: 8'h00, exp_rdata: 8'h5A};
        vecs[6] = '{is_b: 1'b1, wr: 1'b0, addr: 10'h3FF, wdata: 8'h00, exp_rdata: 8'hA5};

        rst = 1'b0;
        a_req = 0; a_wr = 0; a_addr = '0; a_wdata = '0;
        b_req = 0; b_wr = 0; b_addr = '0; b_wdata = '0;
        clr_req = 0;
        tick();
        tick();
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_cs", {31'd0, ram_cs}, 0);
        check("rst_gnts", {30'd0, a_gnt, b_gnt}, 0);
        check("rst_rdata", {16'd0, a_rdata, b_rdata}, 0);
        rst = 1'b1;
        tick();

        // Async reset while an access is on the RAM pins.
        drive(1'b0, 1'b1, 1'b1, 10'h001, 8'h99);
        wait_gnt(1'b0, ok);
        check("pre_rst_gnt", {31'd0, ok}, 1);
        check("pre_rst_cs", {31'd0, ram_cs}, 1);
        #1 rst = 1'b0;
        #1;
        check("async_rst_cs", {31'd0, ram_cs}, 0);
        check("async_rst_wr", {31'd0, ram_wr}, 0);
        check("async_rst_gnt", {31'd0, a_gnt}, 0);
        check("async_rst_busy", {31'd0, busy}, 0);
        check("async_rst_addr", {22'd0, ram_addr}, 0);
        drive(1'b0, 1'b0, 1'b0, 10'h000, 8'h00);
        tick();
        rst = 1'b1;
        tick();

        // Simultaneous first requests: A wins the first tie.
        drive(1'b0, 1'b1, 1'b1, 10'h010, 8'h11);
        drive(1'b1, 1'b1, 1'b1, 10'h020, 8'h22);
        tick();
        check("tie_a_first", {31'd0, a_gnt}, 1);
        check("tie_b_waits", {31'd0, b_gnt}, 0);
        check("tie_addr", {22'd0, ram_addr}, 10'h010);
        a_req = 1'b0;
        wait_gnt(1'b1, ok);
        check("tie_b_next", {31'd0, ok}, 1);
        check("tie_b_addr", {22'd0, ram_addr}, 10'h020);
        b_req = 1'b0;
        tick();

        // Table of single-client writes and reads.
        for (int i = 0; i < 7; i++) begin
            do_access($sformatf("vec%0d", i), vecs[i].is_b, vecs[i].wr,
                      vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata);
        end

        // Both clients hold req for six grants; B was granted last, so A leads.
        drive(1'b0, 1'b1, 1'b0, 10'h3FF, 8'h00);
        drive(1'b1, 1'b1, 1'b0, 10'h000, 8'h00);
        for (int c = 0; c < 40 && grants < 6; c++) cont_step();
        check("cont_six_grants", grants, 6);
        for (int c = 0; c < 3; c++) cont_step();
        check("cont_final_a", {24'd0, a_rdata}, 8'hA5);
        check("cont_final_b", {24'd0, b_rdata}, 8'h5A);
        check("cont_idle", {31'd0, busy}, 0);

        // Clear outranks a pending A read of 0x3FF.
        drive(1'b0, 1'b1, 1'b0, 10'h3FF, 8'h00);
        clr_req = 1'b1;
        tick();
        check("clr_ram_rst", {31'd0, ram_rst}, 1);
        check("clr_no_gnt", {31'd0, a_gnt}, 0);
        check("clr_done_not_yet", {31'd0, clr_done}, 0);
        clr_req = 1'b0;
        tick();
        check("clr_done", {31'd0, clr_done}, 1);
        check("clr_rst_drop", {31'd0, ram_rst}, 0);
        check("clr_still_no_gnt", {31'd0, a_gnt}, 0);
        tick();
        check("clr_then_gnt", {31'd0, a_gnt}, 1);
        check("clr_then_rd", {31'd0, ram_rd}, 1);
        a_req = 1'b0;
        tick();
        tick();
        check("clr_rvalid", {31'd0, a_rvalid}, 1);
        check("clr_rdata_zero", {24'd0, a_rdata}, 8'h00);
        exp_a_rdata = 8'h00;

        // Reset in RDWAIT discards the read; the next read completes normally.
        do_access("wr77", 1'b0, 1'b1, 10'h3FF, 8'h77, 8'h00);
        drive(1'b0, 1'b1, 1'b0, 10'h3FF, 8'h00);
        wait_gnt(1'b0, ok);
        check("mid_rd_gnt", {31'd0, ok}, 1);
        a_req = 1'b0;
        tick();
        check("mid_rd_busy", {31'd0, busy}, 1);
        #1 rst = 1'b0;
        #1;
        check("mid_rd_rvalid", {31'd0, a_rvalid}, 0);
        check("mid_rd_busy_clr", {31'd0, busy}, 0);
        exp_a_rdata = 8'h00;
        exp_b_rdata = 8'h00;
        for (int c = 0; c < 2; c++) begin
            tick();
            check("in_rst_no_rvalid", {31'd0, a_rvalid}, 0);
        end
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            check("post_rst_no_rvalid", {31'd0, a_rvalid}, 0);
        end
        do_access("post_rst_rd", 1'b0, 1'b0, 10'h3FF, 8'h00, 8'h77);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
